// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the fetch FSM state enum and the default bus widths.
package fetch_pkg;
   localparam int ARQ_DEF    = 16;
   localparam int ADDR_W_DEF = 13;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus: imem_req/imem_addr out, imem_rdata/imem_valid in.
// master = fetch side, slave = memory side.
interface fetch_stage_if
   import fetch_pkg::*;
#(
   parameter int ARQ    = ARQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [ARQ-1:0]    imem_rdata;
   logic              imem_valid;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata, imem_valid
   );
   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata, imem_valid
   );
endinterface

// File: rtl/pc_reg.sv
// Program counter: load (priority) or increment, wrapping mod 2^ADDR_W.
// Ports: clk, rst (async active-low), load_i/load_val_i, inc_i, pc_o, pc_inc_o.
module pc_reg
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_inc_o
);
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   assign pc_inc_o = pc_q + 1'b1;
   assign pc_o     = pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load_i)
         pc_d = load_val_i;
      else if (inc_i)
         pc_d = pc_inc_o;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding imem request, skid buffer, IF/ID register.
// Ports: clk, rst, stall, jump_en/jump_addr, imem (master), instr/instr_pc/instr_valid.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                ARQ      = ARQ_DEF,
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   fetch_stage_if.master     imem,
   output logic [ARQ-1:0]    instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid
);
   fetch_state_e      state_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [ARQ-1:0]    instr_q;
   logic [ADDR_W-1:0] instr_pc_q;
   logic              valid_q;
   logic [ARQ-1:0]    buf_data_q;
   logic [ADDR_W-1:0] buf_pc_q;

   logic              pc_load;
   logic              pc_inc;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_nxt;

   assign pc_load = jump_en && (state_q != BOOT);
   assign pc_inc  = ((state_q == REQ) && imem.imem_valid && !stall)
                 || ((state_q == HOLD) && !stall);

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst        (rst),
      .load_i     (pc_load),
      .load_val_i (jump_addr),
      .inc_i      (pc_inc),
      .pc_o       (pc),
      .pc_inc_o   (pc_nxt)
   );

   assign imem.imem_req  = (state_q == REQ) || (state_q == DRAIN);
   assign imem.imem_addr = req_addr_q;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign instr_valid    = valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= BOOT;
         req_addr_q <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         buf_data_q <= '0;
         buf_pc_q   <= '0;
      end else begin
         case (state_q)
            BOOT: begin
               state_q    <= REQ;
               req_addr_q <= RESET_PC;
            end
            REQ: begin
               if (jump_en) begin
                  valid_q <= 1'b0;
                  // data in flight can only be dropped once it lands
                  if (imem.imem_valid)
                     req_addr_q <= jump_addr;
                  else
                     state_q <= DRAIN;
               end else if (imem.imem_valid) begin
                  if (stall) begin
                     buf_data_q <= imem.imem_rdata;
                     buf_pc_q   <= req_addr_q;
                     state_q    <= HOLD;
                  end else begin
                     instr_q    <= imem.imem_rdata;
                     instr_pc_q <= req_addr_q;
                     valid_q    <= 1'b1;
                     req_addr_q <= pc_nxt;
                  end
               end
            end
            DRAIN: begin
               if (jump_en)
                  valid_q <= 1'b0;
               // a jump landing with the stale data wins over the old pc
               if (imem.imem_valid) begin
                  req_addr_q <= jump_en ? jump_addr : pc;
                  state_q    <= REQ;
               end
            end
            HOLD: begin
               if (jump_en) begin
                  valid_q    <= 1'b0;
                  buf_data_q <= '0;
                  buf_pc_q   <= '0;
                  req_addr_q <= jump_addr;
                  state_q    <= REQ;
               end else if (!stall) begin
                  instr_q    <= buf_data_q;
                  instr_pc_q <= buf_pc_q;
                  valid_q    <= 1'b1;
                  req_addr_q <= pc_nxt;
                  state_q    <= REQ;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized stream
// checked against an in-order program-counter model.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam int ARQ = 16;
   localparam int AW  = 13;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          stall     = 1'b0;
   logic          jump_en   = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic [ARQ-1:0] instr;
   logic [AW-1:0]  instr_pc;
   logic           instr_valid;

   fetch_stage_if #(.ARQ(ARQ), .ADDR_W(AW)) imem ();

   fetch_stage #(
      .ARQ      (ARQ),
      .ADDR_W   (AW),
      .RESET_PC ('0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .imem        (imem),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // memory model: a request is answered once it has been presented
   // for lat_cur cycles; data is looked up at the (stable) request address
   int lat_cfg = 1;
   bit rnd_lat = 1'b0;
   bit force_v = 1'b0;
   int age     = 0;
   int lat_cur = 1;

   function automatic logic [ARQ-1:0] mem_word(input logic [AW-1:0] a);
      return 16'(32'(a) * 7 + 32'h1234);
   endfunction

   assign imem.imem_valid = force_v || (imem.imem_req && (age >= lat_cur - 1));
   assign imem.imem_rdata = mem_word(imem.imem_addr);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         age     <= 0;
         lat_cur <= lat_cfg;
      end else if (imem.imem_valid) begin
         age     <= 0;
         lat_cur <= rnd_lat ? int'($urandom_range(1, 3)) : lat_cfg;
      end else if (imem.imem_req) begin
         age <= age + 1;
      end else begin
         age <= 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst     = 1'b0;
      stall   = 1'b0;
      jump_en = 1'b0;
      force_v = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) tick();
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", instr_valid); end
      n_tests++; if (instr !== '0) begin n_fail++; $display("FAIL rst_instr: got %0h want 0", instr); end
      n_tests++; if (instr_pc !== '0) begin n_fail++; $display("FAIL rst_pc: got %0h want 0", instr_pc); end
      n_tests++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0h want 0", imem.imem_req); end
      n_tests++; if (imem.imem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", imem.imem_addr); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %0h want 0", imem.imem_req); end
      tick();
      n_tests++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL boot_to_req: got %0h want 1", imem.imem_req); end
   endtask

   task automatic test_stream();
      lat_cfg = 1;
      reset_dut();
      tick();
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first: got %0h want 0", instr_valid); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr !== mem_word(AW'(i))) begin
            n_fail++;
            $display("FAIL stream_%0d: got v=%0h pc=%0h d=%0h want v=1 pc=%0h d=%0h",
                     i, instr_valid, instr_pc, instr, i, mem_word(AW'(i)));
         end
      end
   endtask

   task automatic test_stall();
      lat_cfg = 1;
      reset_dut();
      repeat (6) tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (instr_pc !== AW'(4) || instr_valid !== 1'b1 || imem.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got pc=%0h v=%0h req=%0h want pc=4 v=1 req=0",
                     i, instr_pc, instr_valid, imem.imem_req);
         end
      end
      stall = 1'b0;
      tick();
      n_tests++;
      if (instr_pc !== AW'(5) || instr !== mem_word(AW'(5)) || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: got pc=%0h d=%0h want pc=5 d=%0h", instr_pc, instr, mem_word(AW'(5)));
      end
      tick();
      n_tests++; if (instr_pc !== AW'(6)) begin n_fail++; $display("FAIL stall_next: got %0h want 6", instr_pc); end
   endtask

   task automatic test_jump_drain();
      int k;
      lat_cfg = 1;
      reset_dut();
      repeat (2) tick();
      lat_cfg   = 3;
      jump_en   = 1'b1;
      jump_addr = 13'h010;
      tick();
      jump_en = 1'b0;
      n_tests++; if (imem.imem_addr !== 13'h010 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL jd_req010: got a=%0h v=%0h want a=10 v=0", imem.imem_addr, instr_valid); end
      tick();
      jump_en   = 1'b1;
      jump_addr = 13'h100;
      tick();
      jump_en = 1'b0;
      n_tests++; if (imem.imem_addr !== 13'h010 || imem.imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL jd_drain: got a=%0h r=%0h v=%0h want a=10 r=1 v=0", imem.imem_addr, imem.imem_req, instr_valid); end
      tick();
      n_tests++; if (imem.imem_addr !== 13'h100 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL jd_redirect: got a=%0h v=%0h want a=100 v=0", imem.imem_addr, instr_valid); end
      k = 0;
      while (k < 10) begin
         tick();
         k++;
         if (instr_valid) break;
      end
      n_tests++; if (k !== 3) begin n_fail++; $display("FAIL jd_latency: got %0d cycles want 3", k); end
      n_tests++; if (instr_pc !== 13'h100 || instr !== mem_word(13'h100)) begin n_fail++; $display("FAIL jd_data: got pc=%0h d=%0h want pc=100 d=%0h", instr_pc, instr, mem_word(13'h100)); end
   endtask

   task automatic test_jump_stall();
      lat_cfg = 1;
      reset_dut();
      repeat (3) tick();
      stall = 1'b1;
      tick();
      n_tests++; if (imem.imem_req !== 1'b0 || instr_pc !== AW'(1)) begin n_fail++; $display("FAIL js_hold: got r=%0h pc=%0h want r=0 pc=1", imem.imem_req, instr_pc); end
      jump_en   = 1'b1;
      jump_addr = 13'h0AA;
      tick();
      n_tests++; if (instr_valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 13'h0AA) begin n_fail++; $display("FAIL js_hold_jump: got v=%0h r=%0h a=%0h want v=0 r=1 a=aa", instr_valid, imem.imem_req, imem.imem_addr); end
      jump_en = 1'b0;
      stall   = 1'b0;
      tick();
      n_tests++; if (instr_pc !== 13'h0AA || instr !== mem_word(13'h0AA) || instr_valid !== 1'b1) begin n_fail++; $display("FAIL js_land: got pc=%0h d=%0h want pc=aa d=%0h", instr_pc, instr, mem_word(13'h0AA)); end
      stall     = 1'b1;
      jump_en   = 1'b1;
      jump_addr = 13'h123;
      tick();
      n_tests++; if (instr_valid !== 1'b0 || imem.imem_addr !== 13'h123) begin n_fail++; $display("FAIL js_req_jump: got v=%0h a=%0h want v=0 a=123", instr_valid, imem.imem_addr); end
      stall   = 1'b0;
      jump_en = 1'b0;
      tick();
      n_tests++; if (instr_pc !== 13'h123 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL js_land2: got pc=%0h v=%0h want pc=123 v=1", instr_pc, instr_valid); end
   endtask

   task automatic test_wrap();
      lat_cfg = 1;
      reset_dut();
      tick();
      jump_en   = 1'b1;
      jump_addr = 13'h1FFF;
      tick();
      jump_en = 1'b0;
      tick();
      n_tests++; if (instr_pc !== 13'h1FFF || imem.imem_addr !== 13'h0000) begin n_fail++; $display("FAIL wrap_addr: got pc=%0h a=%0h want pc=1fff a=0", instr_pc, imem.imem_addr); end
      tick();
      n_tests++; if (instr_pc !== 13'h0000 || instr !== mem_word(13'h0000)) begin n_fail++; $display("FAIL wrap_pc: got pc=%0h d=%0h want pc=0 d=%0h", instr_pc, instr, mem_word(13'h0)); end
   endtask

   task automatic test_reset_drain();
      lat_cfg = 1;
      reset_dut();
      repeat (2) tick();
      lat_cfg = 3;
      tick();
      jump_en   = 1'b1;
      jump_addr = 13'h055;
      tick();
      jump_en = 1'b0;
      n_tests++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== AW'(2) || instr_pc !== AW'(1)) begin n_fail++; $display("FAIL rd_drain: got r=%0h a=%0h pc=%0h want r=1 a=2 pc=1", imem.imem_req, imem.imem_addr, instr_pc); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if ({instr_valid, instr, instr_pc, imem.imem_req, imem.imem_addr} !== '0) begin n_fail++; $display("FAIL rd_async: got v=%0h d=%0h pc=%0h r=%0h a=%0h want all 0", instr_valid, instr, instr_pc, imem.imem_req, imem.imem_addr); end
      force_v = 1'b1;
      lat_cfg = 1;
      repeat (2) tick();
      n_tests++; if ({instr_valid, instr, instr_pc, imem.imem_req} !== '0) begin n_fail++; $display("FAIL rd_ignore: got v=%0h d=%0h pc=%0h r=%0h want all 0", instr_valid, instr, instr_pc, imem.imem_req); end
      force_v = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      n_tests++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== '0) begin n_fail++; $display("FAIL rd_restart: got r=%0h a=%0h want r=1 a=0", imem.imem_req, imem.imem_addr); end
      tick();
      n_tests++; if (instr_pc !== '0 || instr_valid !== 1'b1 || instr !== mem_word('0)) begin n_fail++; $display("FAIL rd_first: got pc=%0h v=%0h d=%0h want pc=0 v=1", instr_pc, instr_valid, instr); end
   endtask

   // Reference: instructions must reach decode strictly in program order,
   // restarting at the latest jump target; stall freezes the outputs.
   task automatic test_random();
      logic [AW-1:0]  exp_pc;
      logic           p_valid;
      logic [AW-1:0]  p_pc;
      logic [ARQ-1:0] p_instr;
      logic           p_req;
      logic           p_mv;
      logic [AW-1:0]  p_addr;
      int             deliv;
      rnd_lat = 1'b1;
      lat_cfg = 2;
      reset_dut();
      tick();
      exp_pc = '0;
      deliv  = 0;
      for (int i = 0; i < 800; i++) begin
         stall   = ($urandom % 100) < 30;
         jump_en = ($urandom % 100) < 7;
         if (($urandom % 4) == 0)
            jump_addr = 13'h1FFC;
         else
            jump_addr = AW'($urandom);
         p_valid = instr_valid;
         p_pc    = instr_pc;
         p_instr = instr;
         p_req   = imem.imem_req;
         p_mv    = imem.imem_valid;
         p_addr  = imem.imem_addr;
         tick();
         n_tests++;
         if (jump_en) begin
            if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_jump_kill @%0d: got v=%0h want 0", i, instr_valid); end
            exp_pc = jump_addr;
         end else if (!stall && instr_valid && (!p_valid || instr_pc !== p_pc)) begin
            deliv++;
            if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
               n_fail++;
               $display("FAIL rnd_order @%0d: got pc=%0h d=%0h want pc=%0h d=%0h", i, instr_pc, instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 1'b1;
         end else if ({instr_valid, instr_pc, instr} !== {p_valid, p_pc, p_instr}) begin
            n_fail++;
            $display("FAIL rnd_hold @%0d: got v=%0h pc=%0h d=%0h want v=%0h pc=%0h d=%0h",
                     i, instr_valid, instr_pc, instr, p_valid, p_pc, p_instr);
         end
         if (p_req && !p_mv) begin
            n_tests++;
            if (imem.imem_addr !== p_addr) begin n_fail++; $display("FAIL rnd_addr_stable @%0d: got %0h want %0h", i, imem.imem_addr, p_addr); end
         end
      end
      stall   = 1'b0;
      jump_en = 1'b0;
      rnd_lat = 1'b0;
      n_tests++; if (deliv < 80) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >= 80", deliv); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_jump_drain();
      test_jump_stall();
      test_wrap();
      test_reset_drain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
